// File: rtl/prog_ram_pkg.sv
// Shared parameters for the program RAM: default address/word widths
// and the LOAD/RUN state encoding.
package prog_ram_pkg;

  localparam int adlines   = 8;
  localparam int datalines = 16;

  localparam logic ST_LOAD = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    LOAD = ST_LOAD,
    RUN  = ST_RUN
  } state_t;

endpackage

// File: rtl/prog_ram_loader.sv
// Load/run sequencer for the program RAM: owns the FSM, the loader
// write pointer and the accepted-word counter.
module prog_ram_loader
  import prog_ram_pkg::*;
#(
  parameter int ADLINES = adlines
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic               load_last,
  input  logic               reload,
  output logic               load_ready,
  output logic               enable,
  output logic               run,
  output logic               we,
  output logic [ADLINES-1:0] wptr,
  output logic [ADLINES-1:0] load_count
);

  localparam logic [ADLINES-1:0] PTR0 = ADLINES'(1);

  state_t state_q, state_d;
  logic   at_top;

  assign run        = (state_q == RUN);
  assign load_ready = (state_q == LOAD);
  assign at_top     = &wptr;

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    unique case (state_q)
      LOAD: begin
        we = load_valid;
        if (load_valid && (load_last || at_top))
          state_d = RUN;
      end
      RUN: begin
        if (reload)
          state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Address 0 is reserved: the CPU pre-increments pc before its first fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      wptr       <= PTR0;
      load_count <= '0;
      enable     <= 1'b0;
    end else begin
      state_q <= state_d;
      enable  <= run && !reload;
      if (we) begin
        if (!at_top)
          wptr <= wptr + 1'b1;
        load_count <= load_count + 1'b1;
      end else if (run && reload) begin
        wptr       <= PTR0;
        load_count <= '0;
      end
    end
  end

endmodule

// File: rtl/prog_ram.sv
// Program RAM: loaded word-by-word from a stream loader, then served
// to the control unit with a zero-latency read path.
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int ADLINES   = adlines,
  parameter int DATALINES = datalines
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADLINES-1:0]   addressbus,
  input  logic                 read,
  input  logic                 write,
  input  logic [DATALINES-1:0] toram,
  output logic [DATALINES-1:0] fromram,
  output logic                 enable,
  input  logic                 load_valid,
  input  logic [DATALINES-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  input  logic                 reload,
  output logic [ADLINES-1:0]   load_count
);

  logic [DATALINES-1:0] mem [2**ADLINES];
  logic [DATALINES-1:0] rdata;
  logic [DATALINES-1:0] hold_q;
  logic                 run;
  logic                 we;
  logic [ADLINES-1:0]   wptr;

  prog_ram_loader #(
    .ADLINES(ADLINES)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_last (load_last),
    .reload    (reload),
    .load_ready(load_ready),
    .enable    (enable),
    .run       (run),
    .we        (we),
    .wptr      (wptr),
    .load_count(load_count)
  );

  assign rdata = mem[addressbus];

  // Array is deliberately not reset so a warm reset keeps the program.
  always_ff @(posedge clk) begin
    if (we)
      mem[wptr] <= load_data;
    else if (run && write)
      mem[addressbus] <= toram;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_q <= '0;
    else if (run && read)
      hold_q <= rdata;
  end

  assign fromram = (run && read) ? rdata : hold_q;

endmodule

// File: tb/tb_prog_ram.sv
// Self-checking bench for prog_ram: directed load/run sequences,
// a vector table and a randomized run phase against a memory model.
module tb_prog_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addressbus;
  logic        read, write, load_valid, load_last, reload;
  logic [15:0] toram, load_data;
  logic [15:0] fromram;
  logic        enable, load_ready;
  logic [7:0]  load_count;

  logic        rst4_n;
  logic [3:0]  addr4;
  logic        read4, write4, lv4, ll4, reload4;
  logic [15:0] toram4, ld4;
  logic [15:0] fromram4;
  logic        enable4, lr4;
  logic [3:0]  lc4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prog_ram dut (
    .clk(clk), .rst_n(rst_n), .addressbus(addressbus),
    .read(read), .write(write), .toram(toram), .fromram(fromram),
    .enable(enable), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .reload(reload), .load_count(load_count)
  );

  prog_ram #(.ADLINES(4), .DATALINES(16)) dut4 (
    .clk(clk), .rst_n(rst4_n), .addressbus(addr4),
    .read(read4), .write(write4), .toram(toram4), .fromram(fromram4),
    .enable(enable4), .load_valid(lv4), .load_data(ld4),
    .load_last(ll4), .load_ready(lr4),
    .reload(reload4), .load_count(lc4)
  );

  typedef struct {
    logic [7:0]  a;
    logic        rd;
    logic        wr;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[9];

  logic [15:0] m [256];
  bit          v [256];
  logic [15:0] hold_m;
  bit          hv;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a,
                        input logic [15:0] exp);
    addressbus = a;
    read       = 1'b1;
    #1;
    chk(nm, fromram, exp);
    step();
    read = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    addressbus = '0; read = 0; write = 0; toram = '0;
    load_valid = 0; load_last = 0; reload = 0; load_data = '0;
    addr4 = '0; read4 = 0; write4 = 0; toram4 = '0;
    lv4 = 0; ll4 = 0; reload4 = 0; ld4 = '0;
    foreach (v[i]) v[i] = 1'b0;

    tbl[0] = '{8'd1, 1, 0, 16'h0000, 16'h1111};
    tbl[1] = '{8'd2, 1, 0, 16'h0000, 16'h2222};
    tbl[2] = '{8'd3, 1, 0, 16'h0000, 16'h3333};
    tbl[3] = '{8'd2, 1, 0, 16'h0000, 16'h2222};
    tbl[4] = '{8'd9, 0, 0, 16'h0000, 16'h2222};
    tbl[5] = '{8'd5, 0, 1, 16'h1234, 16'h2222};
    tbl[6] = '{8'd5, 1, 1, 16'hBEEF, 16'h1234};
    tbl[7] = '{8'd5, 1, 0, 16'h0000, 16'hBEEF};
    tbl[8] = '{8'd7, 0, 0, 16'h0000, 16'hBEEF};

    #12;
    chk("rst_enable", 16'(enable), 16'd0);
    chk("rst_ready", 16'(load_ready), 16'd1);
    chk("rst_count", 16'(load_count), 16'd0);
    chk("rst_fromram", fromram, 16'h0000);
    #5 rst_n = 1'b1; rst4_n = 1'b1;
    step();

    load_word(16'h1111, 1'b0);
    chk("ld1_count", 16'(load_count), 16'd1);
    load_word(16'h2222, 1'b0);
    chk("ld2_count", 16'(load_count), 16'd2);
    chk("ld2_ready", 16'(load_ready), 16'd1);
    load_word(16'h3333, 1'b1);
    chk("ld3_count", 16'(load_count), 16'd3);
    chk("ld3_ready", 16'(load_ready), 16'd0);
    chk("ld3_enable_early", 16'(enable), 16'd0);
    step();
    chk("ld3_enable", 16'(enable), 16'd1);
    chk("run_count", 16'(load_count), 16'd3);

    foreach (tbl[i]) begin
      addressbus = tbl[i].a;
      read       = tbl[i].rd;
      write      = tbl[i].wr;
      toram      = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d", i), fromram, tbl[i].exp);
      step();
    end
    read = 0; write = 0;

    m[1] = 16'h1111; v[1] = 1;
    m[2] = 16'h2222; v[2] = 1;
    m[3] = 16'h3333; v[3] = 1;
    m[5] = 16'hBEEF; v[5] = 1;
    hold_m = 16'hBEEF; hv = 1;

    for (int n = 0; n < 300; n++) begin
      logic [7:0]  a;
      logic        rd, wr;
      logic [15:0] d, e;
      bit          ev;
      a  = 8'($urandom_range(4, 255));
      rd = 1'($urandom);
      wr = ($urandom_range(0, 3) == 0);
      d  = 16'($urandom);
      addressbus = a; read = rd; write = wr; toram = d;
      e  = rd ? m[a] : hold_m;
      ev = rd ? v[a] : hv;
      #1;
      if (ev) chk("rand_fromram", fromram, e);
      if (rd) begin hold_m = m[a]; hv = v[a]; end
      if (wr) begin m[a] = d; v[a] = 1; end
      step();
    end
    read = 0; write = 0;

    rd_chk("pre_reload_rd1", 8'd1, 16'h1111);
    reload = 1; write = 1; addressbus = 8'd10; toram = 16'hCAFE;
    step();
    reload = 0; write = 0;
    chk("reload_enable", 16'(enable), 16'd0);
    chk("reload_ready", 16'(load_ready), 16'd1);
    chk("reload_count", 16'(load_count), 16'd0);
    addressbus = 8'd2; write = 1; toram = 16'hDEAD; read = 1;
    #1;
    chk("load_rd_held", fromram, 16'h1111);
    step();
    write = 0; read = 0;
    chk("load_wr_ignored_cnt", 16'(load_count), 16'd0);
    load_word(16'hAAAA, 1'b1);
    chk("reload_ld_count", 16'(load_count), 16'd1);
    step();
    chk("reload_run_enable", 16'(enable), 16'd1);
    rd_chk("reload_rd1", 8'd1, 16'hAAAA);
    rd_chk("reload_rd2", 8'd2, 16'h2222);
    rd_chk("reload_wr10", 8'd10, 16'hCAFE);

    reload = 1;
    step();
    reload = 0;
    load_word(16'h5001, 1'b0);
    load_word(16'h5002, 1'b0);
    chk("mid_count2", 16'(load_count), 16'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 16'(load_count), 16'd0);
    chk("mid_rst_ready", 16'(load_ready), 16'd1);
    chk("mid_rst_enable", 16'(enable), 16'd0);
    chk("mid_rst_fromram", fromram, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    load_word(16'h6001, 1'b1);
    chk("mid_ld_count", 16'(load_count), 16'd1);
    step();
    chk("mid_enable", 16'(enable), 16'd1);
    rd_chk("mid_rd1", 8'd1, 16'h6001);
    rd_chk("mid_rd2", 8'd2, 16'h5002);
    rd_chk("mid_rd3", 8'd3, 16'h3333);

    for (int i = 1; i <= 15; i++) begin
      lv4 = 1; ld4 = 16'h4000 | 16'(i); ll4 = 0;
      step();
      chk($sformatf("a4_count%0d", i), 16'(lc4), 16'(i));
      chk($sformatf("a4_ready%0d", i), 16'(lr4), (i < 15) ? 16'd1 : 16'd0);
    end
    chk("a4_enable_early", 16'(enable4), 16'd0);
    ld4 = 16'hFFFF;
    step();
    lv4 = 0;
    chk("a4_count_hold", 16'(lc4), 16'd15);
    chk("a4_enable", 16'(enable4), 16'd1);
    read4 = 1;
    for (int i = 1; i <= 15; i++) begin
      addr4 = 4'(i);
      #1;
      chk($sformatf("a4_rd%0d", i), fromram4, 16'h4000 | 16'(i));
    end
    read4 = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_ram.md
PROG_RAM -- requirements
Module: prog_ram

Interface
REQ-001: Parameter ADLINES, default 8, address width; taken from the shared parameter file (adlines).
REQ-002: Parameter DATALINES, default 16, word width; taken from the shared parameter file (datalines).
REQ-003: clk  input  1  single clock; all state changes on posedge clk.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: addressbus  input  ADLINES  word address from the control unit.
REQ-006: read  input  1  control-unit read strobe.
REQ-007: write  input  1  control-unit write strobe.
REQ-008: toram  input  DATALINES  write data from the control unit.
REQ-009: fromram  output  DATALINES  read data to the control unit.
REQ-010: enable  output  1  run permission to the control unit; high only in RUN.
REQ-011: load_valid  input  1  loader word available.
REQ-012: load_data  input  DATALINES  loader word.
REQ-013: load_last  input  1  qualifies load_valid; marks the final program word.
REQ-014: load_ready  output  1  high only in LOAD.
REQ-015: reload  input  1  single-cycle request to return to LOAD.
REQ-016: load_count  output  ADLINES  number of words accepted in the current load.

Function
REQ-017: Storage: 2^ADLINES words of DATALINES bits.
REQ-018: FSM states: LOAD, RUN; encoding per the shared parameter file.
REQ-019: LOAD: load_ready=1, enable=0; a word transfers on a posedge with load_valid=1.
REQ-020: Each transferred word is written to mem[load_ptr], then load_ptr increments and load_count increments.
REQ-021: load_ptr starts at address 1, because the control unit pre-increments pc from 0 before its first fetch; address 0 is never written by the loader.
REQ-022: LOAD -> RUN on the posedge that transfers a word with load_last=1.
REQ-023: LOAD -> RUN also on the posedge that transfers a word at load_ptr = 2^ADLINES-1; load_ptr does not wrap.
REQ-024: load_valid=0 in LOAD: no write, pointer and count held, no timeout.
REQ-025: RUN: enable=1 (registered, rises on the first posedge after the LOAD -> RUN transition), load_ready=0, loader inputs ignored.
REQ-026: RUN read path: fromram = mem[addressbus] combinationally while read=1, so data is valid before the next posedge (zero-cycle read latency).
REQ-027: RUN, read=0: fromram holds the last value presented with read=1 (holding register updated each posedge with read=1).
REQ-028: RUN write: posedge with write=1 sets mem[addressbus] <= toram.
REQ-029: read=1 and write=1 on the same posedge: write performed; fromram shows pre-write contents during that cycle.
REQ-030: read and write in LOAD: ignored (no memory change, fromram held).
REQ-031: reload=1 in RUN: next state LOAD, enable=0 from the next posedge, load_ptr=1, load_count=0, memory contents retained; any write on the same posedge still completes.
REQ-032: reload in LOAD: ignored.

Reset
REQ-033: rst_n low, asynchronously: state=LOAD, enable=0, load_ready=1 after release, load_ptr=1, load_count=0, fromram=0.
REQ-034: Memory array is not cleared by reset.
REQ-035: Reset mid-load: loading restarts at address 1; words already written stay in memory.

Structure
REQ-036: ADLINES, DATALINES and the LOAD/RUN state encodings reside in the shared parameter include.
REQ-037: One sub-module, prog_ram_loader (FSM + load_ptr/load_count); the array and read path stay in prog_ram.

Verification
REQ-038: Reset, load 3 words 0x1111, 0x2222, 0x3333 (last on the 3rd) -> mem[1..3] hold them, load_count=3, enable rises 1 cycle after the 3rd transfer.
REQ-039: RUN, addressbus=2, read=1 -> fromram=0x2222 in the same cycle; read dropped -> fromram stays 0x2222.
REQ-040: RUN, write=1, addressbus=5, toram=0xBEEF, with read=1 -> fromram shows old mem[5] that cycle; next read of 5 returns 0xBEEF.
REQ-041: ADLINES=4, load 15 words with no last -> RUN after the word at address 15, load_count=15, no wrap to address 0.
REQ-042: reload pulse in RUN -> enable=0 next cycle, load_ready=1, load_count=0; then load 1 word 0xAAAA with last -> mem[1]=0xAAAA, mem[2]=0x2222 retained.
REQ-043: rst_n asserted after 2 of 4 load words -> state LOAD, load_count=0; the next word lands at address 1.
